// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask helper for the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } sram_state_e;

    // Byte lanes touched by a transfer of 2^hsize bytes starting at offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] hsize, input logic [2:0] offset);
        logic [15:0] base;
        logic [15:0] m;
        case (hsize[1:0])
            2'd0:    base = 16'h0001;
            2'd1:    base = 16'h0003;
            2'd2:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        m = base << offset;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mem_sram_be.sv
// 1R1W synchronous RAM with per-byte write enables and a registered, read-first output.
module mem_sram_be #(
    parameter int WORDS = 2048,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wbe,
    input  logic [63:0]   i_wdata
);

    logic [63:0] mem_q [WORDS];
    logic [63:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wbe[b]) mem_q[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Same-address read and write in one cycle returns the old word; the top forwards.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  rdata_q <= '0;
        else if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave: address/data pipelining, byte-lane writes, wait states,
// read-after-write forwarding and a two-cycle ERROR response.
module ahb_sram
    import ahb_pkg::*;
#(
    parameter int WORDS       = 2048,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [2:0]  i_hburst,
    input  logic [2:0]  i_hsize,
    input  logic [3:0]  i_hprot,
    input  logic [1:0]  i_htrans,
    input  logic [63:0] i_hwdata,
    input  logic        i_hwrite,
    input  logic        i_hready,
    output logic [63:0] o_hrdata,
    output logic        o_hresp,
    output logic        o_hready
);

    localparam int          AW         = $clog2(WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(WORDS) << 3;
    localparam logic [2:0]  WS_INIT    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    sram_state_e   state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          wr_pend_q, wr_pend_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [7:0]    fwd_mask_q, fwd_mask_d;
    logic [63:0]   fwd_data_q, fwd_data_d;

    logic          active, accept, xfer_err, align_err;
    logic          wr_commit, rd_en, fwd_hit;
    logic [AW-1:0] word_idx;
    logic [63:0]   ram_rdata;
    logic          unused_ok;

    assign unused_ok = ^{i_hburst, i_hprot};

    assign active   = (htrans_e'(i_htrans) == HTRANS_NONSEQ) || (htrans_e'(i_htrans) == HTRANS_SEQ);
    assign accept   = i_hsel && active && i_hready;
    assign word_idx = i_haddr[AW+2:3];

    always_comb begin
        align_err = 1'b0;
        case (hsize_e'(i_hsize))
            HSIZE_HALF:  align_err = i_haddr[0];
            HSIZE_WORD:  align_err = |i_haddr[1:0];
            HSIZE_DWORD: align_err = |i_haddr[2:0];
            default:     align_err = 1'b0;
        endcase
    end

    assign xfer_err = (i_haddr >= ADDR_LIMIT) || (i_hsize > 3'd3) || align_err;

    // A pending write lands in the cycle its data phase completes (HREADYOUT high in IDLE).
    assign wr_commit = (state_q == ST_IDLE) && wr_pend_q && i_rst_n;
    assign rd_en     = accept && !xfer_err && !i_hwrite && i_rst_n;
    assign fwd_hit   = wr_commit && (waddr_q == word_idx);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_pend_d  = wr_commit ? 1'b0 : wr_pend_q;
        waddr_d    = waddr_q;
        wmask_d    = wmask_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (xfer_err) begin
                state_d   = ST_ERR1;
                wr_pend_d = 1'b0;
            end else begin
                state_d   = (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
                cnt_d     = WS_INIT;
                wr_pend_d = i_hwrite;
                waddr_d   = word_idx;
                wmask_d   = lane_mask(i_hsize, i_haddr[2:0]);
                if (!i_hwrite) begin
                    // Overlay the bytes being written this same cycle onto the RAM's old word.
                    fwd_mask_d = fwd_hit ? wmask_q : 8'h00;
                    fwd_data_d = i_hwdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            wr_pend_q  <= 1'b0;
            waddr_q    <= '0;
            wmask_q    <= 8'h00;
            fwd_mask_q <= 8'h00;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pend_q  <= wr_pend_d;
            waddr_q    <= waddr_d;
            wmask_q    <= wmask_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    mem_sram_be #(.WORDS(WORDS)) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_re    (rd_en),
        .i_raddr (word_idx),
        .o_rdata (ram_rdata),
        .i_we    (wr_commit),
        .i_waddr (waddr_q),
        .i_wbe   (wmask_q),
        .i_wdata (i_hwdata)
    );

    always_comb begin
        o_hrdata = ram_rdata;
        for (int b = 0; b < 8; b++) begin
            if (fwd_mask_q[b]) o_hrdata[b*8 +: 8] = fwd_data_q[b*8 +: 8];
        end
    end

    assign o_hready = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram.sv
// Scoreboard bench: a zero-wait instance and a two-wait-state instance on a shared bus.
module tb_ahb_sram;

    localparam int WORDS = 64;

    typedef struct {
        logic        err;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel2, hwrite;
    logic [31:0] haddr;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [63:0] hwdata;
    logic [63:0] rdata0, rdata2;
    logic        resp0, resp2, rdy0, rdy2;

    exp_t        exp_q[$];
    logic [63:0] mdl0 [WORDS];
    logic [63:0] mdl2 [WORDS];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ahb_sram #(.WORDS(WORDS), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsel(sel0), .i_haddr(haddr), .i_hburst(hburst),
        .i_hsize(hsize), .i_hprot(hprot), .i_htrans(htrans), .i_hwdata(hwdata),
        .i_hwrite(hwrite), .i_hready(rdy0), .o_hrdata(rdata0), .o_hresp(resp0), .o_hready(rdy0)
    );

    ahb_sram #(.WORDS(WORDS), .WAIT_STATES(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsel(sel2), .i_haddr(haddr), .i_hburst(hburst),
        .i_hsize(hsize), .i_hprot(hprot), .i_htrans(htrans), .i_hwdata(hwdata),
        .i_hwrite(hwrite), .i_hready(rdy2), .o_hrdata(rdata2), .o_hresp(resp2), .o_hready(rdy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input bit d2, input bit wr, input logic [31:0] a, input logic [2:0] sz);
        sel0   = !d2;
        sel2   = d2;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic idle();
        sel0   = 1'b0;
        sel2   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    function automatic void mdl_wr(input bit d2, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [63:0] wd);
        int w   = int'(a >> 3);
        int off = int'(a[2:0]);
        for (int b = 0; b < 8; b++) begin
            if (b >= off && b < off + (1 << sz)) begin
                if (d2) mdl2[w][b*8 +: 8] = wd[b*8 +: 8];
                else    mdl0[w][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
    endfunction

    function automatic logic [63:0] mdl_rd(input bit d2, input logic [31:0] a);
        return d2 ? mdl2[int'(a >> 3)] : mdl0[int'(a >> 3)];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checks++;
        if (rdy0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== 64'h0) begin
            errors++; $display("FAIL reset_dut0 got rdy=%b resp=%b rdata=%h exp 1 0 0", rdy0, resp0, rdata0);
        end
        checks++;
        if (rdy2 !== 1'b1 || resp2 !== 1'b0 || rdata2 !== 64'h0) begin
            errors++; $display("FAIL reset_dut2 got rdy=%b resp=%b rdata=%h exp 1 0 0", rdy2, resp2, rdata2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        exp_t e;
        addr_phase(0, 1, 32'h10, 3);
        tick();
        hwdata = 64'h1122334455667788; mdl_wr(0, 32'h10, 3, hwdata); idle();
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL wr_hready got %b exp 1", rdy0); end
        tick();
        addr_phase(0, 1, 32'h0, 3);
        tick();
        hwdata = 64'h0F0E0D0C0B0A0908; mdl_wr(0, 32'h0, 3, hwdata); idle();
        tick();
        addr_phase(0, 0, 32'h10, 3); exp_q.push_back('{1'b0, mdl_rd(0, 32'h10)});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (rdy0 !== 1'b1 || rdata0 !== e.data || rdata0 !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_dword got rdy=%b %h exp 1 %h", rdy0, rdata0, e.data);
        end
        // byte write onto lane 3; other lanes carry junk that must be ignored
        addr_phase(0, 1, 32'h13, 0);
        tick();
        hwdata = 64'hEEEEEEEE_ABEEEEEE; mdl_wr(0, 32'h13, 0, hwdata); idle();
        checks++;
        if (rdata0 !== 64'h1122334455667788) begin
            errors++; $display("FAIL rdata_hold got %h exp %h", rdata0, 64'h1122334455667788);
        end
        tick();
        addr_phase(0, 0, 32'h10, 3); exp_q.push_back('{1'b0, mdl_rd(0, 32'h10)});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (rdata0 !== e.data || rdata0 !== 64'h11223344AB667788) begin
            errors++; $display("FAIL rd_byte_merge got %h exp %h", rdata0, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        addr_phase(0, 1, 32'h20, 3);
        tick();
        hwdata = 64'hCAFEF00D_12345678; mdl_wr(0, 32'h20, 3, hwdata);
        addr_phase(0, 0, 32'h20, 3); exp_q.push_back('{1'b0, mdl_rd(0, 32'h20)});
        tick();
        hwdata = 64'h0;
        addr_phase(0, 1, 32'h26, 1);
        e = exp_q.pop_front();
        checks++;
        if (rdy0 !== 1'b1 || rdata0 !== e.data) begin
            errors++; $display("FAIL fwd_full got rdy=%b %h exp 1 %h", rdy0, rdata0, e.data);
        end
        tick();
        hwdata = 64'hBEEF0000_00000000; mdl_wr(0, 32'h26, 1, hwdata);
        addr_phase(0, 0, 32'h20, 3); exp_q.push_back('{1'b0, mdl_rd(0, 32'h20)});
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_hready got %b exp 1", rdy0); end
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (rdy0 !== 1'b1 || rdata0 !== e.data || rdata0 !== 64'hBEEFF00D_12345678) begin
            errors++; $display("FAIL fwd_partial got rdy=%b %h exp 1 %h", rdy0, rdata0, e.data);
        end
        tick();
    endtask

    task automatic test_error();
        exp_t        e;
        logic [31:0] ea [4];
        logic [2:0]  es [4];
        logic        ew [4];
        logic [63:0] held;
        ea = '{32'(WORDS * 8), 32'h1, 32'h4, 32'h8};
        es = '{3'd3, 3'd1, 3'd3, 3'd4};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            held = rdata0;
            addr_phase(0, ew[i], ea[i], es[i]); exp_q.push_back('{1'b1, 64'h0});
            tick();
            hwdata = '1; idle();
            checks++;
            if (rdy0 !== 1'b0 || resp0 !== 1'b1) begin
                errors++; $display("FAIL err1_case%0d got rdy=%b resp=%b exp 0 1", i, rdy0, resp0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (rdy0 !== 1'b1 || resp0 !== e.err || rdata0 !== held) begin
                errors++; $display("FAIL err2_case%0d got rdy=%b resp=%b rdata=%h exp 1 1 %h", i, rdy0, resp0, rdata0, held);
            end
            // a new transfer is accepted in the second error cycle
            hwdata = 64'h0;
            addr_phase(0, 0, 32'h0, 3); exp_q.push_back('{1'b0, mdl_rd(0, 32'h0)});
            tick();
            idle();
            e = exp_q.pop_front();
            checks++;
            if (rdy0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== e.data) begin
                errors++; $display("FAIL err_after_case%0d got rdy=%b resp=%b %h exp 1 0 %h", i, rdy0, resp0, rdata0, e.data);
            end
        end
    endtask

    task automatic test_random_b2b();
        exp_t        e;
        localparam int N = 40;
        logic        p_wr = 1'b0, c_wr = 1'b0;
        logic [31:0] p_a = '0, a = '0;
        logic [2:0]  p_sz = '0, sz = '0;
        logic [63:0] p_wd = '0, wd = '0;
        for (int i = 0; i <= N; i++) begin
            if (p_wr) begin hwdata = p_wd; mdl_wr(0, p_a, p_sz, p_wd); end
            else      hwdata = 64'h0;
            if (i < N) begin
                if (i < 8) begin
                    c_wr = 1'b1; sz = 3'd3; a = 32'(64 + 8 * i);
                end else begin
                    c_wr = 1'($urandom_range(0, 1));
                    sz   = 3'($urandom_range(0, 3));
                    a    = 32'((8 + $urandom_range(0, 7)) * 8 + ($urandom_range(0, 7) & ~((1 << sz) - 1)));
                end
                wd = {$urandom, $urandom};
                addr_phase(0, c_wr, a, sz);
                if (!c_wr) exp_q.push_back('{1'b0, mdl_rd(0, a)});
            end else begin
                idle();
            end
            tick();
            checks++;
            if (rdy0 !== 1'b1) begin errors++; $display("FAIL rnd_hready_%0d got %b exp 1", i, rdy0); end
            if (i < N && !c_wr) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata0 !== e.data) begin
                    errors++; $display("FAIL rnd_read_%0d addr=%h got %h exp %h", i, a, rdata0, e.data);
                end
            end
            p_wr = (i < N) && c_wr; p_a = a; p_sz = sz; p_wd = wd;
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        int   n;
        addr_phase(1, 1, 32'h40, 3);
        tick();
        hwdata = 64'hA5A5_5A5A_0102_0304; mdl_wr(1, 32'h40, 3, hwdata); idle();
        n = 0;
        while (rdy2 !== 1'b1 && n < 10) begin n++; tick(); end
        checks++;
        if (n != 2) begin errors++; $display("FAIL ws_write_lows got %0d exp 2", n); end
        tick();
        addr_phase(1, 0, 32'h40, 3); exp_q.push_back('{1'b0, mdl_rd(1, 32'h40)});
        tick();
        idle();
        n = 0;
        while (rdy2 !== 1'b1 && n < 10) begin n++; tick(); end
        checks++;
        if (n != 2) begin errors++; $display("FAIL ws_read_lows got %0d exp 2", n); end
        e = exp_q.pop_front();
        checks++;
        if (rdy2 !== 1'b1 || resp2 !== 1'b0 || rdata2 !== e.data) begin
            errors++; $display("FAIL ws_read_data got rdy=%b resp=%b %h exp 1 0 %h", rdy2, resp2, rdata2, e.data);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        int   n;
        addr_phase(1, 1, 32'h48, 3);
        tick();
        hwdata = 64'h1357_9BDF_2468_ACE0; mdl_wr(1, 32'h48, 3, hwdata); idle();
        n = 0;
        while (rdy2 !== 1'b1 && n < 10) begin n++; tick(); end
        tick();
        addr_phase(1, 1, 32'h48, 3);
        tick();
        hwdata = 64'hDEAD_DEAD_DEAD_DEAD; idle();
        rst_n = 1'b0;
        checks++;
        if (rdy2 !== 1'b0) begin errors++; $display("FAIL rst_pre_wait got rdy=%b exp 0", rdy2); end
        tick();
        checks++;
        if (rdy2 !== 1'b1 || resp2 !== 1'b0 || rdata2 !== 64'h0) begin
            errors++; $display("FAIL rst_mid_wait got rdy=%b resp=%b %h exp 1 0 0", rdy2, resp2, rdata2);
        end
        rst_n = 1'b1;
        hwdata = 64'h0;
        tick();
        addr_phase(1, 0, 32'h48, 3); exp_q.push_back('{1'b0, mdl_rd(1, 32'h48)});
        tick();
        idle();
        n = 0;
        while (rdy2 !== 1'b1 && n < 10) begin n++; tick(); end
        e = exp_q.pop_front();
        checks++;
        if (n == 10 || rdata2 !== e.data) begin
            errors++; $display("FAIL rst_word_kept got %h exp %h (waits %0d)", rdata2, e.data, n);
        end
    endtask

    initial begin
        hburst = 3'd0; hprot = 4'd0; hwdata = 64'h0; haddr = 32'h0; hsize = 3'd0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_error();
        test_random_b2b();
        test_wait_states();
        test_reset_mid_write();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
